// File: rtl/hms_updown_counter_pkg.sv
// rtl/hms_updown_counter_pkg.sv - shared direction encoding, field widths and load range helper
package hms_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;
  localparam int LD_W  = 6;

  // Full 6-bit compare, so an hour load with bit 5 set is always out of range.
  function automatic logic below_mod(input logic [LD_W-1:0] val, input int modulus);
    return int'(val) < modulus;
  endfunction

endpackage

// File: rtl/hms_updown_counter_if.sv
// rtl/hms_updown_counter_if.sv - control strobes and time outputs of the h:m:s counter
interface hms_updown_counter_if;
  import hms_updown_counter_pkg::*;

  logic              clear;
  logic              tick;
  logic              dir;
  logic              load_sec;
  logic              load_min;
  logic              load_hr;
  logic [LD_W-1:0]   load_data;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HR_W-1:0]   hr;
  logic              sec_wrap;
  logic              min_wrap;
  logic              day_wrap;
  logic              load_err;

  modport master (
    output clear, tick, dir, load_sec, load_min, load_hr, load_data,
    input  sec, min, hr, sec_wrap, min_wrap, day_wrap, load_err
  );

  modport slave (
    input  clear, tick, dir, load_sec, load_min, load_hr, load_data,
    output sec, min, hr, sec_wrap, min_wrap, day_wrap, load_err
  );

endinterface

// File: rtl/hms_updown_counter_stage.sv
// rtl/hms_updown_counter_stage.sv - one modulo-N up/down field with load and combinational carry/borrow
module mod_n_ud_stage
  import hms_updown_counter_pkg::*;
#(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         co
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic         at_edge;
  logic [W-1:0] cnt_nxt;

  // Wrap is decided by explicit compare against the field limit, not by overflow.
  assign at_edge = (dir == DIR_DOWN) ? (cnt == '0) : (cnt == MAX);
  assign co      = en & at_edge;

  always_comb begin
    cnt_nxt = cnt;
    if (ld) begin
      cnt_nxt = ld_val;
    end else if (en) begin
      if (dir == DIR_DOWN) begin
        cnt_nxt = at_edge ? MAX : cnt - ONE;
      end else begin
        cnt_nxt = at_edge ? '0 : cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/hms_updown_counter.sv
// rtl/hms_updown_counter.sv - hours:minutes:seconds up/down counter with validated field loads
module hms_updown_counter
  import hms_updown_counter_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  hms_updown_counter_if.slave  bus
);

  logic load_any;
  logic one_strobe;
  logic in_range;
  logic load_ok;
  logic step;
  logic sec_ld, min_ld, hr_ld;
  logic sec_co, min_co, hr_co;
  logic [SEC_W-1:0] sec_ld_val;
  logic [MIN_W-1:0] min_ld_val;
  logic [HR_W-1:0]  hr_ld_val;

  assign load_any   = bus.load_sec | bus.load_min | bus.load_hr;
  assign one_strobe = (bus.load_sec ^ bus.load_min ^ bus.load_hr) &
                      ~(bus.load_sec & bus.load_min & bus.load_hr);
  assign in_range   = bus.load_sec ? below_mod(bus.load_data, SEC_MOD) :
                      bus.load_min ? below_mod(bus.load_data, MIN_MOD) :
                                     below_mod(bus.load_data, HOUR_MOD);
  assign load_ok    = one_strobe & in_range;

  // clear beats any load, and any load cycle (accepted or not) swallows the tick.
  assign step = bus.tick & ~load_any & ~bus.clear;

  // clear is realised as a load of zero into every stage.
  assign sec_ld = bus.clear | (load_ok & bus.load_sec);
  assign min_ld = bus.clear | (load_ok & bus.load_min);
  assign hr_ld  = bus.clear | (load_ok & bus.load_hr);

  assign sec_ld_val = bus.clear ? '0 : bus.load_data[SEC_W-1:0];
  assign min_ld_val = bus.clear ? '0 : bus.load_data[MIN_W-1:0];
  assign hr_ld_val  = bus.clear ? '0 : bus.load_data[HR_W-1:0];

  mod_n_ud_stage #(.W(SEC_W), .MOD(SEC_MOD)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (step),
    .dir    (bus.dir),
    .ld     (sec_ld),
    .ld_val (sec_ld_val),
    .cnt    (bus.sec),
    .co     (sec_co)
  );

  mod_n_ud_stage #(.W(MIN_W), .MOD(MIN_MOD)) u_min (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_co),
    .dir    (bus.dir),
    .ld     (min_ld),
    .ld_val (min_ld_val),
    .cnt    (bus.min),
    .co     (min_co)
  );

  mod_n_ud_stage #(.W(HR_W), .MOD(HOUR_MOD)) u_hr (
    .clk    (clk),
    .rst    (rst),
    .en     (min_co),
    .dir    (bus.dir),
    .ld     (hr_ld),
    .ld_val (hr_ld_val),
    .cnt    (bus.hr),
    .co     (hr_co)
  );

  // Pulses line up with the edge on which the wrapped value becomes visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sec_wrap <= 1'b0;
      bus.min_wrap <= 1'b0;
      bus.day_wrap <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      bus.sec_wrap <= sec_co;
      bus.min_wrap <= min_co;
      bus.day_wrap <= hr_co;
      bus.load_err <= load_any & ~load_ok & ~bus.clear;
    end
  end

endmodule
